// File: rtl/quad_step_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : quad_step_decoder                                               |
// | Brief  : Quadrature A/B decoder with sync, glitch filter, step/dir/err.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module quad_step_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic en,
  input  logic err_clr,
  output logic step,
  output logic up,
  output logic err
);

  localparam logic [4:0] c_PRIME_INIT = 5'(FILT_LEN + 2);
  localparam logic [3:0] c_FCNT_MAX   = 4'(FILT_LEN - 1);

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;
  logic [4:0] r_prime;
  logic [1:0] w_filt;
  logic [1:0] w_changed;
  logic       w_priming;
  logic       w_dir_up;

  assign w_priming = (r_prime != 5'd0);

  // Bit 1 is channel A, bit 0 is channel B throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {enc_a, enc_b};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= c_PRIME_INIT;
    end else if (w_priming) begin
      r_prime <= r_prime - 5'd1;
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_filt
      logic [3:0] r_fcnt;
      logic       r_filt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fcnt <= 4'd0;
          r_filt <= 1'b0;
        end else if (w_priming) begin
          r_fcnt <= 4'd0;
          r_filt <= r_sync2[i];
        end else if (r_sync2[i] == r_filt) begin
          r_fcnt <= 4'd0;
        end else if (r_fcnt == c_FCNT_MAX) begin
          r_fcnt <= 4'd0;
          r_filt <= r_sync2[i];
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end

      assign w_filt[i] = r_filt;
    end
  endgenerate

  assign w_changed = w_filt ^ r_prev;
  // For a single-bit change, new A differing from old B means the up sequence.
  assign w_dir_up  = w_filt[1] ^ r_prev[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 2'b00;
      step   <= 1'b0;
      up     <= 1'b1;
      err    <= 1'b0;
    end else begin
      r_prev <= w_priming ? r_sync2 : w_filt;
      step   <= !w_priming && en && (^w_changed);
      if (!w_priming && en && (^w_changed)) begin
        up <= w_dir_up;
      end
      if (!w_priming && en && (&w_changed)) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : tb_quad_step_decoder                                            |
// | Brief  : Self-checking bench: vector table, corner sequences, random.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_quad_step_decoder;

  localparam int FILT_LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic en = 1'b1;
  logic err_clr = 1'b0;
  logic step, up, err;

  quad_step_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
    .en(en), .err_clr(err_clr), .step(step), .up(up), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int step_seen = 0;
  logic check_model = 1'b0;

  // Reference model: encoder position arithmetic on a 4-position wheel.
  logic [1:0] m_pipe [2];
  logic [1:0] m_filt, m_prev;
  int m_run [2];
  int m_prime;
  logic m_step, m_up, m_err;

  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_pipe[0] = 2'b00; m_pipe[1] = 2'b00;
    m_filt = 2'b00; m_prev = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
    m_prime = FILT_LEN + 2;
    m_step = 1'b0; m_up = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] synced;
    int delta;
    synced = m_pipe[1];
    if (m_prime > 0) begin
      m_filt = synced;
      m_prev = synced;
      m_prime--;
      m_step = 1'b0;
      if (err_clr) m_err = 1'b0;
    end else begin
      delta = (pos(m_filt) - pos(m_prev) + 4) % 4;
      m_step = en && (delta == 1 || delta == 3);
      if (en && (delta == 1 || delta == 3)) m_up = (delta == 1);
      if (en && delta == 2) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_prev = m_filt;
      for (int ch = 0; ch < 2; ch++) begin
        if (synced[ch] != m_filt[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == FILT_LEN) begin
            m_filt[ch] = synced[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
    end
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = {enc_a, enc_b};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    if (step === 1'b1) step_seen++;
    if (check_model) begin
      chk("rand_step", {31'd0, step}, {31'd0, m_step});
      chk("rand_up",   {31'd0, up},   {31'd0, m_up});
      chk("rand_err",  {31'd0, err},  {31'd0, m_err});
    end
  endtask

  typedef struct {
    logic [1:0] ab;
    logic       en;
    logic       clr;
    int         hold;
    int         steps;
    logic       up;
    logic       err;
  } vec_t;

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 20, 0, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[3]  = '{2'b10, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 1'b1, 1'b0, 20, 0, 1'b0, 1'b0};
    vecs[12] = '{2'b10, 1'b1, 1'b0, 3,  0, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 1'b1, 1'b0, 20, 0, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 1'b1, 1'b0, 10, 0, 1'b0, 1'b1};
    vecs[15] = '{2'b11, 1'b1, 1'b1, 1,  0, 1'b0, 1'b0};
    vecs[16] = '{2'b11, 1'b1, 1'b0, 5,  0, 1'b0, 1'b0};
    vecs[17] = '{2'b00, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0};
    vecs[18] = '{2'b10, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0};
    vecs[19] = '{2'b11, 1'b0, 1'b0, 10, 0, 1'b0, 1'b0};
    vecs[20] = '{2'b11, 1'b1, 1'b0, 10, 0, 1'b0, 1'b0};
    vecs[21] = '{2'b01, 1'b1, 1'b0, 10, 1, 1'b1, 1'b0};
    vecs[22] = '{2'b10, 1'b1, 1'b0, 10, 0, 1'b1, 1'b1};

    model_reset();
    repeat (3) tick();
    chk("reset_step", {31'd0, step}, 32'd0);
    chk("reset_up",   {31'd0, up},   32'd1);
    chk("reset_err",  {31'd0, err},  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      {enc_a, enc_b} = vecs[i].ab;
      en = vecs[i].en;
      err_clr = vecs[i].clr;
      step_seen = 0;
      repeat (vecs[i].hold) tick();
      err_clr = 1'b0;
      chk($sformatf("vec%0d_steps", i), step_seen, vecs[i].steps);
      chk($sformatf("vec%0d_up", i),    {31'd0, up},  {31'd0, vecs[i].up});
      chk($sformatf("vec%0d_err", i),   {31'd0, err}, {31'd0, vecs[i].err});
    end

    // Clear coincident with a fresh illegal jump: the set must win.
    {enc_a, enc_b} = 2'b01;
    repeat (6) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_vs_set_err", {31'd0, err}, 32'd1);
    chk("clr_vs_set_step", {31'd0, step}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_alone_err", {31'd0, err}, 32'd0);

    // Latency: 01 -> 00 is an up step registered at edge FILT_LEN+3.
    {enc_a, enc_b} = 2'b00;
    repeat (6) tick();
    chk("lat_edge6_step", {31'd0, step}, 32'd0);
    tick();
    chk("lat_edge7_step", {31'd0, step}, 32'd1);
    chk("lat_edge7_up",   {31'd0, up},   32'd1);
    tick();
    chk("lat_edge8_step", {31'd0, step}, 32'd0);

    // Put up=0 and err=1, then reset asynchronously mid-operation.
    {enc_a, enc_b} = 2'b01;
    repeat (10) tick();
    {enc_a, enc_b} = 2'b10;
    repeat (10) tick();
    chk("pre_rst_up",  {31'd0, up},  32'd0);
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_step", {31'd0, step}, 32'd0);
    chk("async_rst_up",   {31'd0, up},   32'd1);
    chk("async_rst_err",  {31'd0, err},  32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    step_seen = 0;
    repeat (20) tick();
    chk("reprime_steps", step_seen, 32'd0);
    chk("reprime_err",   {31'd0, err}, 32'd0);

    check_model = 1'b1;
    for (int seg = 0; seg < 400; seg++) begin
      {enc_a, enc_b} = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      err_clr = ($urandom_range(0, 19) == 0);
      repeat ($urandom_range(1, 12)) tick();
    end
    check_model = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
